plot_sink_fb_writer: RTL and testbench

- Consumer end of the pixel-plot interface (x, y, colour, plot) driven by the board/animation drawing path.
- Accepts plot writes into an 8-entry FIFO and clips any write outside 320x240.
- Converts each coordinate pair to a linear framebuffer address (y*320 + x) in a pipeline.
- Issues the writes on a framebuffer write port with a ready/valid handshake, so drawing engines are decoupled from framebuffer arbitration.

---
 rtl/fb_pkg.sv | 20 ++
 rtl/plot_fifo.sv | 51 +++++
 rtl/plot_sink_fb_writer.sv | 151 +++++++++++++++
 tb/tb_plot_sink_fb_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and the queued plot-entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fb_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int FB_WORDS = H_RES * V_RES;  // 76800
  localparam int ADDR_W   = 17;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } plot_entry_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO, power-of-two depth, wrap-bit pointers.
// Latency: a pushed entry is visible at o_dout the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together allowed.
//
// Ports: clock/resetn; i_push/i_din write side; i_pop read side;
//        o_dout head entry; o_full/o_empty status.
module plot_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  // Same index with differing wrap bit means the writer is a full lap ahead.
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/plot_sink_fb_writer.sv
// Pixel-plot sink: clip to screen, queue, convert (x,y) to y*320+x, write framebuffer.
// Latency: plot accepted at edge E drives fb_wren=1 right after edge E+3 (fb_ready=1).
// Backpressure: fb_ready=0 freezes all stages and FIFO pops; ready=!full stalls the plotter.
//
// Ports: clock, resetn (async, active low); x, y, colour, plot input request;
//        ready = FIFO not full; fb_addr/fb_data/fb_wren/fb_ready framebuffer port;
//        busy = any work queued or in flight; drop_count saturating clip count;
//        overflow sticky "plot while not ready".
module plot_sink_fb_writer #(
  parameter int H_RES      = fb_pkg::H_RES,
  parameter int V_RES      = fb_pkg::V_RES,
  parameter int COLOUR_W   = fb_pkg::COLOUR_W,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = fb_pkg::ADDR_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [9:0]          x,
  input  logic [8:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot,
  output logic                ready,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic                fb_wren,
  input  logic                fb_ready,
  output logic                busy,
  output logic [7:0]          drop_count,
  output logic                overflow
);

  import fb_pkg::*;

  localparam logic [9:0] X_LIM = 10'(H_RES);
  localparam logic [8:0] Y_LIM = 9'(V_RES);

  plot_entry_t w_push_entry;
  plot_entry_t w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_clip;
  logic        w_push;
  logic        w_pop;
  logic        w_advance;
  logic [ADDR_W-1:0] w_y_ext;
  logic [ADDR_W-1:0] w_ybase;
  logic [ADDR_W-1:0] w_addr;

  // S1: head fields plus partial product y*320
  logic                r_s1_vld;
  logic [9:0]          r_s1_x;
  logic [COLOUR_W-1:0] r_s1_colour;
  logic [ADDR_W-1:0]   r_s1_ybase;
  // S2: full linear address
  logic                r_s2_vld;
  logic [ADDR_W-1:0]   r_s2_addr;
  logic [COLOUR_W-1:0] r_s2_colour;
  // S3: the framebuffer port registers themselves
  logic                r_s3_vld;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic [COLOUR_W-1:0] r_fb_data;

  logic [7:0] r_drop_count;
  logic       r_overflow;

  assign w_push_entry.x      = x;
  assign w_push_entry.y      = y;
  assign w_push_entry.colour = colour;

  always_comb begin
    w_clip    = (x >= X_LIM) || (y >= Y_LIM);
    w_push    = plot && !w_full && !w_clip;
    // One advance signal for every stage: whole pipe moves or whole pipe holds,
    // so order is preserved and no entry is duplicated or lost.
    w_advance = !r_s3_vld || fb_ready;
    w_pop     = w_advance && !w_empty;
    // y*320 = (y<<8) + (y<<6), built at address width so nothing truncates.
    w_y_ext   = ADDR_W'(w_head.y);
    w_ybase   = (w_y_ext << 8) + (w_y_ext << 6);
    w_addr    = r_s1_ybase + ADDR_W'(r_s1_x);
  end

  plot_fifo #(
    .WIDTH ($bits(plot_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s1_vld    <= 1'b0;
      r_s1_x      <= '0;
      r_s1_colour <= '0;
      r_s1_ybase  <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_addr   <= '0;
      r_s2_colour <= '0;
      r_s3_vld    <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_data   <= '0;
    end else if (w_advance) begin
      r_s1_vld <= w_pop;
      if (w_pop) begin
        r_s1_x      <= w_head.x;
        r_s1_colour <= w_head.colour;
        r_s1_ybase  <= w_ybase;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_addr   <= w_addr;
        r_s2_colour <= r_s1_colour;
      end
      // Address/data only load with a valid entry, so they hold the last
      // written values while fb_wren is low.
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_fb_addr <= r_s2_addr;
        r_fb_data <= r_s2_colour;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (plot && !w_full && w_clip && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 8'd1;
      if (plot && w_full)
        r_overflow <= 1'b1;
    end
  end

  assign ready      = !w_full;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;
  assign fb_wren    = r_s3_vld;
  assign busy       = !w_empty || r_s1_vld || r_s2_vld || r_s3_vld;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_plot_sink_fb_writer.sv
module tb_plot_sink_fb_writer;

  logic        clock;
  logic        resetn;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        ready;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_wren;
  logic        fb_ready;
  logic        busy;
  logic [7:0]  drop_count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wren_cycles = 0;

  logic [16:0] q_addr [$];
  logic [2:0]  q_data [$];
  int          q_cyc  [$];

  plot_sink_fb_writer dut (
    .clock      (clock),
    .resetn     (resetn),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .ready      (ready),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_wren    (fb_wren),
    .fb_ready   (fb_ready),
    .busy       (busy),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every completed handshake (stamped with the edge that revealed it).
  always @(negedge clock) begin
    if (resetn && fb_wren) begin
      wren_cycles++;
      if (fb_ready) begin
        q_addr.push_back(fb_addr);
        q_data.push_back(fb_data);
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0; fb_ready = 1'b1;
    tick(); tick();
    n_checks++; if (fb_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", fb_wren); end
    n_checks++; if (fb_addr !== 17'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", fb_addr); end
    n_checks++; if (fb_data !== 3'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", fb_data); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    resetn = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || fb_wren !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy=%b wren=%b expected 0 0", busy, fb_wren); end
  endtask

  task automatic test_single_write();
    int e;
    int w0;
    logic [16:0] a;
    logic [2:0]  d;
    int          c;
    clear_q();
    fb_ready = 1'b1;
    w0 = wren_cycles;
    x = 10'd5; y = 9'd2; colour = 3'b101; plot = 1'b1;
    tick();
    e = cyc;
    plot = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    a = (q_addr.size() > 0) ? q_addr[0] : 'x;
    d = (q_data.size() > 0) ? q_data[0] : 'x;
    c = (q_cyc.size() > 0) ? q_cyc[0] - e : -1;
    n_checks++; if (q_addr.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d writes expected 1", q_addr.size()); end
    n_checks++; if (a !== 17'd645) begin n_fail++; $display("FAIL single_addr: got %0d expected 645", a); end
    n_checks++; if (d !== 3'b101) begin n_fail++; $display("FAIL single_data: got %b expected 101", d); end
    n_checks++; if (c !== 3) begin n_fail++; $display("FAIL single_latency: got %0d edges expected 3", c); end
    n_checks++; if (wren_cycles - w0 !== 1) begin n_fail++; $display("FAIL single_wren_cycles: got %0d expected 1", wren_cycles - w0); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  xs [3];
    logic [8:0]  ys [3];
    logic [16:0] exp_a [3];
    int bad;
    int e;
    xs[0] = 10'd0;   ys[0] = 9'd0;   exp_a[0] = 17'd0;
    xs[1] = 10'd319; ys[1] = 9'd239; exp_a[1] = 17'd76799;
    xs[2] = 10'd160; ys[2] = 9'd120; exp_a[2] = 17'd38560;
    clear_q();
    fb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = xs[i]; y = ys[i]; colour = 3'(i + 2); plot = 1'b1;
      tick();
      if (i == 0) e = cyc;
    end
    plot = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    n_checks++; if (q_addr.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", q_addr.size()); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (i >= q_addr.size()) bad++;
      else if (q_addr[i] !== exp_a[i] || q_data[i] !== 3'(i + 2) || q_cyc[i] !== e + 3 + i) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_order: %0d entries wrong/out of slot, expected 0", bad); end
  endtask

  task automatic test_clipping();
    logic [16:0] a;
    clear_q();
    fb_ready = 1'b1;
    x = 10'd320; y = 9'd0;   colour = 3'd1; plot = 1'b1; tick();
    x = 10'd0;   y = 9'd240; colour = 3'd2; plot = 1'b1; tick();
    x = 10'd319; y = 9'd239; colour = 3'd3; plot = 1'b1; tick();
    plot = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    a = (q_addr.size() > 0) ? q_addr[0] : 'x;
    n_checks++; if (q_addr.size() !== 1) begin n_fail++; $display("FAIL clip_count: got %0d writes expected 1", q_addr.size()); end
    n_checks++; if (a !== 17'd76799) begin n_fail++; $display("FAIL clip_addr: got %0d expected 76799", a); end
    n_checks++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL clip_drop: got %0d expected 2", drop_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clip_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_backpressure();
    logic [11:0] rdy_seen;
    int bad;
    clear_q();
    fb_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      x = 10'(100 + i); y = 9'd10; colour = 3'(i); plot = 1'b1;
      rdy_seen[i] = ready;
      tick();
    end
    plot = 1'b0;
    tick(); tick();
    n_checks++; if (rdy_seen !== 12'h7FF) begin n_fail++; $display("FAIL bp_ready_seq: got %h expected 7ff", rdy_seen); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", ready); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b expected 1", overflow); end
    n_checks++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL bp_drop: got %0d expected 2", drop_count); end
    n_checks++; if (fb_wren !== 1'b1 || fb_addr !== 17'd3300) begin n_fail++; $display("FAIL bp_hold: wren=%b addr=%0d expected 1 3300", fb_wren, fb_addr); end
    n_checks++; if (q_addr.size() !== 0) begin n_fail++; $display("FAIL bp_no_accept: got %0d writes expected 0", q_addr.size()); end
    fb_ready = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    n_checks++; if (q_addr.size() !== 11) begin n_fail++; $display("FAIL bp_count: got %0d expected 11", q_addr.size()); end
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      if (i >= q_addr.size()) bad++;
      else if (q_addr[i] !== 17'(3300 + i) || q_data[i] !== 3'(i)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_order: %0d entries wrong, expected 0", bad); end
    n_checks++; if (busy !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain: busy=%b ready=%b expected 0 1", busy, ready); end
  endtask

  task automatic test_stall();
    int unstable;
    int bad;
    clear_q();
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = 10'(50 + i); y = 9'd3; colour = 3'(i + 1); plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    n_checks++; if (fb_wren !== 1'b1 || fb_addr !== 17'd1010 || fb_data !== 3'd1) begin n_fail++; $display("FAIL stall_first: wren=%b addr=%0d data=%0d expected 1 1010 1", fb_wren, fb_addr, fb_data); end
    unstable = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (fb_wren !== 1'b1 || fb_addr !== 17'd1010 || fb_data !== 3'd1) unstable++;
    end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL stall_stable: %0d unstable cycles expected 0", unstable); end
    fb_ready = 1'b1;
    tick();
    n_checks++; if (q_addr.size() !== 1 || fb_addr !== 17'd1011) begin n_fail++; $display("FAIL stall_release: writes=%0d addr=%0d expected 1 1011", q_addr.size(), fb_addr); end
    for (int k = 0; k < 8; k++) tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= q_addr.size()) bad++;
      else if (q_addr[i] !== 17'(1010 + i) || q_data[i] !== 3'(i + 1)) bad++;
    end
    n_checks++; if (q_addr.size() !== 4 || bad !== 0) begin n_fail++; $display("FAIL stall_order: writes=%0d bad=%0d expected 4 0", q_addr.size(), bad); end
  endtask

  task automatic test_mid_reset();
    int w0;
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x = 10'(200 + i); y = 9'd5; colour = 3'(i); plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    tick(); tick();
    n_checks++; if (busy !== 1'b1 || fb_wren !== 1'b1) begin n_fail++; $display("FAIL mrst_loaded: busy=%b wren=%b expected 1 1", busy, fb_wren); end
    #3;
    resetn = 1'b0;
    #1;
    n_checks++; if (fb_wren !== 1'b0 || fb_addr !== 17'd0 || fb_data !== 3'd0) begin n_fail++; $display("FAIL mrst_outputs: wren=%b addr=%0d data=%0d expected 0 0 0", fb_wren, fb_addr, fb_data); end
    n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mrst_status: ready=%b busy=%b expected 1 0", ready, busy); end
    n_checks++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mrst_counters: drop=%0d ovf=%b expected 0 0", drop_count, overflow); end
    tick();
    resetn = 1'b1;
    w0 = wren_cycles;
    fb_ready = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    n_checks++; if (wren_cycles - w0 !== 0) begin n_fail++; $display("FAIL mrst_no_write: got %0d wren cycles expected 0", wren_cycles - w0); end
    n_checks++; if (ready !== 1'b1 || drop_count !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mrst_after: ready=%b drop=%0d busy=%b expected 1 0 0", ready, drop_count, busy); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_clipping();
    test_backpressure();
    test_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
